// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN computes multiplies combinationally in one pass.
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_100M,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result,
   output logic            done,
   output logic            alu_complete
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN-1);

   state_t              state, state_nxt;
   logic [2:0]          op_q;
   logic                sign_a, sign_b, special;
   logic [2*XLEN-1:0]   acc;
   logic [XLEN:0]       rem;
   logic [XLEN-1:0]     operand;
   logic [CNT_W-1:0]    cnt;

   // Capture-time decode
   logic                is_div, a_signed, b_signed, cap_sa, cap_sb;
   logic                div_zero, div_ovf, skip_calc;
   logic [XLEN-1:0]     mag_a, mag_b, spec_res;

   always_comb begin
      is_div   = funct3[2];
      a_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      cap_sa   = a_signed & op_a[XLEN-1];
      cap_sb   = b_signed & op_b[XLEN-1];
      mag_a    = cap_sa ? -op_a : op_a;
      mag_b    = cap_sb ? -op_b : op_b;
      div_zero = is_div && (op_b == '0);
      div_ovf  = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
      // funct3[1] separates REM/REMU from DIV/DIVU
      if (div_zero)
         spec_res = funct3[1] ? op_a : '1;
      else
         spec_res = funct3[1] ? '0 : MIN_INT;
`ifdef MULDIV_FAST_MUL_EN
      skip_calc = div_zero || div_ovf || !is_div;
`else
      skip_calc = div_zero || div_ovf;
`endif
   end

   // One iteration of each algorithm
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN+1:0] div_diff;
   logic            div_ok;

   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};
      div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b0, operand};
      div_ok    = !div_diff[XLEN+1];
   end

   // Sign correction and result selection
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   always_comb begin
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      if (special)
         fix_res = acc[XLEN-1:0];
      else if (op_q[2])
         fix_res = op_q[1] ? rem_fix : quo_fix;
      else if (op_q == 3'b000)
         fix_res = prod_fix[XLEN-1:0];
      else
         fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk_100M) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = skip_calc ? FIX : CALC;
         CALC:    if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100M) begin
      if (!rst_n) begin
         result       <= '0;
         done         <= 1'b0;
         alu_complete <= 1'b1;
         cnt          <= '0;
         op_q         <= '0;
         sign_a       <= 1'b0;
         sign_b       <= 1'b0;
         special      <= 1'b0;
         acc          <= '0;
         rem          <= '0;
         operand      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_q         <= funct3;
               sign_a       <= cap_sa;
               sign_b       <= cap_sb;
               special      <= div_zero | div_ovf;
               alu_complete <= 1'b0;
               cnt          <= '0;
               rem          <= '0;
               if (div_zero || div_ovf) begin
                  acc <= {{XLEN{1'b0}}, spec_res};
               end else if (is_div) begin
                  acc     <= {{XLEN{1'b0}}, mag_a};
                  operand <= mag_b;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  acc     <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
                  // Multiplier sits in the low half and shifts out as the product grows in
                  acc     <= {{XLEN{1'b0}}, mag_b};
                  operand <= mag_a;
`endif
               end
            end
            CALC: begin
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
               if (op_q[2]) begin
                  rem             <= div_ok ? div_diff[XLEN:0] : div_shift;
                  acc[XLEN-1:0]   <= {acc[XLEN-2:0], div_ok};
               end else begin
                  acc <= {mul_sum, acc[XLEN-1:1]};
               end
            end
            FIX: begin
               result       <= fix_res;
               done         <= 1'b1;
               alu_complete <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
